mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between an I-cache and a D-cache.
// Three-state grant FSM (IDLE / GNT_I / GNT_D). Memory request signals are
// forwarded combinationally from the granted cache only. The grant is
// released on mem_ready, or when the owner abandons its request.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break ties in favour of
// the cache that was not served last. Without the macro, ties always go to
// the D-cache and the last-served register does not exist.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              proc_reset,
   // I-cache side
   input  logic              ic_read,
   input  logic              ic_write,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic [DATA_W-1:0] ic_wdata,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_ready,
   // D-cache side
   input  logic              dc_read,
   input  logic              dc_write,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_ready,
   // Shared memory side
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   // Current grant
   output logic [1:0]        owner
);

   // Requester indices into the per-requester vectors below.
   localparam int REQ_I = 0;
   localparam int REQ_D = 1;

   // State codes double as the owner encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Per-requester views of the cache ports, index 0 = I-cache, 1 = D-cache.
   logic [1:0]        req_read;
   logic [1:0]        req_write;
   logic [1:0]        req_pending;
   logic [1:0]        req_granted;
   logic [1:0]        req_ready;

   assign req_read  = {dc_read,  ic_read};
   assign req_write = {dc_write, ic_write};

   // Tie-break decision: 1 means the D-cache wins when both are pending.
   logic tie_to_d;

   // Build pending / granted / ready per requester. The ready term only
   // looks at this requester's own grant and the memory, so nothing from the
   // other cache's inputs can reach this cache's outputs.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         localparam logic [1:0] GNT_CODE = 2'(gi + 1);
         assign req_pending[gi] = req_read[gi] | req_write[gi];
         assign req_granted[gi] = (state_reg == state_t'(GNT_CODE));
         // A reset in the same cycle as mem_ready aborts the transfer, so
         // no completion is reported.
         assign req_ready[gi]   = req_granted[gi] & mem_ready & ~proc_reset;
      end
   endgenerate

   assign ic_ready = req_ready[REQ_I];
   assign dc_ready = req_ready[REQ_D];

   // Read data is broadcast; ready alone qualifies it.
   assign ic_rdata = mem_rdata;
   assign dc_rdata = mem_rdata;

   assign owner = state_reg;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // last_served_reg: 0 = I-cache served last (D-cache favoured next),
   //                  1 = D-cache served last (I-cache favoured next).
   logic last_served_reg;
   logic last_served_next;

   assign tie_to_d = ~last_served_reg;

   // Record the winner of every grant taken from IDLE.
   always_comb begin
      last_served_next = last_served_reg;
      if (state_reg == IDLE) begin
         if (state_next == GNT_D) begin
            last_served_next = 1'b1;
         end else if (state_next == GNT_I) begin
            last_served_next = 1'b0;
         end
      end
   end

   // Last-served register; reset favours the D-cache.
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         last_served_reg <= 1'b0;
      end else begin
         last_served_reg <= last_served_next;
      end
   end
`else
   // Fixed priority: the D-cache wins every tie.
   assign tie_to_d = 1'b1;
`endif

   // Grant state register.
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: arbitrate in IDLE, hold a grant until completion or
   // abandonment. mem_ready seen in IDLE is deliberately ignored.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req_pending[REQ_I] && req_pending[REQ_D]) begin
               state_next = tie_to_d ? GNT_D : GNT_I;
            end else if (req_pending[REQ_D]) begin
               state_next = GNT_D;
            end else if (req_pending[REQ_I]) begin
               state_next = GNT_I;
            end
         end
         GNT_I: begin
            if (mem_ready || !req_pending[REQ_I]) begin
               state_next = IDLE;
            end
         end
         GNT_D: begin
            if (mem_ready || !req_pending[REQ_D]) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Memory request mux: only the granted cache is forwarded; IDLE drives
   // all zeros. Simultaneous read+write is passed through untouched.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_reg)
         GNT_I: begin
            mem_read  = ic_read;
            mem_write = ic_write;
            mem_addr  = ic_addr;
            mem_wdata = ic_wdata;
         end
         GNT_D: begin
            mem_read  = dc_read;
            mem_write = dc_write;
            mem_addr  = dc_addr;
            mem_wdata = dc_wdata;
         end
         default: begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
         end
      endcase
   end

endmodule
